i2c_mem_target: RTL

- I2C target (responder) end of the memory-over-I2C path; sits in front of the memory array as the counterpart to the initiator inside i2c_wrapper.
- Oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit device address, takes a memory-address byte, then writes data bytes to memory or serves read data back to the initiator with per-byte ACK/NACK.

---
 rtl/definitions.sv | 22 ++
 rtl/i2c_line_sync.sv | 50 +++++
 rtl/i2c_mem_target.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/definitions.sv
// Shared constants and FSM state encoding for the I2C memory target.
package definitions;

  localparam int ADDRWIDTH = 8;
  localparam int DATAWIDTH = 8;
  localparam logic [6:0] I2C_DEV_ADDR = 7'h50;

  typedef logic [3:0] i2c_tgt_state_e;

  localparam i2c_tgt_state_e ST_IDLE      = 4'd0;
  localparam i2c_tgt_state_e ST_DEV_ADDR  = 4'd1;
  localparam i2c_tgt_state_e ST_DEV_ACK   = 4'd2;
  localparam i2c_tgt_state_e ST_REG_ADDR  = 4'd3;
  localparam i2c_tgt_state_e ST_REG_ACK   = 4'd4;
  localparam i2c_tgt_state_e ST_WR_DATA   = 4'd5;
  localparam i2c_tgt_state_e ST_WR_ACK    = 4'd6;
  localparam i2c_tgt_state_e ST_RD_LOAD   = 4'd7;
  localparam i2c_tgt_state_e ST_RD_DATA   = 4'd8;
  localparam i2c_tgt_state_e ST_RD_ACK    = 4'd9;
  localparam i2c_tgt_state_e ST_WAIT_STOP = 4'd10;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for SCL/SDA plus registered edge, START and STOP detection.
// Events are single-cycle pulses appearing 3 clk after the pin change.
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] are the synchronizer stages, [2] is the previous synced value
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       sda_sync_q;
  logic       scl_rise_q;
  logic       scl_fall_q;
  logic       start_det_q;
  logic       stop_det_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_q       <= 3'b111;
      sda_q       <= 3'b111;
      sda_sync_q  <= 1'b1;
      scl_rise_q  <= 1'b0;
      scl_fall_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
    end else begin
      scl_q       <= {scl_q[1:0], scl_in};
      sda_q       <= {sda_q[1:0], sda_in};
      sda_sync_q  <= sda_q[1];
      scl_rise_q  <= scl_q[1] & ~scl_q[2];
      scl_fall_q  <= ~scl_q[1] & scl_q[2];
      start_det_q <= scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
      stop_det_q  <= scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    end
  end

  assign sda_sync  = sda_sync_q;
  assign scl_rise  = scl_rise_q;
  assign scl_fall  = scl_fall_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;

endmodule

// File: rtl/i2c_mem_target.sv
// I2C target bridging a device-address/register-address protocol onto a simple memory port.
// Optional macro I2C_AUTO_INC_EN: address pointer advances after every data byte.
module i2c_mem_target
  import definitions::*;
#(
  parameter logic [6:0] DEV_ADDR  = I2C_DEV_ADDR,
  parameter int         ADDRWIDTH = definitions::ADDRWIDTH,
  parameter int         DATAWIDTH = definitions::DATAWIDTH,
  parameter int         READ_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic                 busy
);

`ifdef I2C_AUTO_INC_EN
  localparam logic AUTO_INC = 1'b1;
`else
  localparam logic AUTO_INC = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_sync  (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_tgt_state_e       state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           tx_q, tx_d;
  logic [ADDRWIDTH-1:0] addr_ptr_q, addr_ptr_d;
  logic                 rw_q, rw_d;
  logic                 phase_q, phase_d;
  logic [3:0]           rd_cnt_q, rd_cnt_d;
  logic                 busy_q, busy_d;
  logic                 sda_oe_q, sda_oe_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  logic [ADDRWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]           byte_in;
  logic                 rd_issue;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    addr_ptr_d  = addr_ptr_q;
    rw_d        = rw_q;
    phase_d     = phase_q;
    rd_cnt_d    = rd_cnt_q;
    busy_d      = busy_q;
    sda_oe_d    = sda_oe_q;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_issue    = 1'b0;
    byte_in     = {shift_q[6:0], sda_s};

    if (start_det) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              case (state_q)
                ST_DEV_ADDR: begin
                  if (byte_in[7:1] == DEV_ADDR) begin
                    state_d = ST_DEV_ACK;
                    rw_d    = byte_in[0];
                    busy_d  = 1'b1;
                  end else begin
                    state_d = ST_WAIT_STOP;
                  end
                end
                ST_REG_ADDR: begin
                  addr_ptr_d = byte_in[ADDRWIDTH-1:0];
                  state_d    = ST_REG_ACK;
                end
                default: begin
                  mem_wr_en_d = 1'b1;
                  mem_addr_d  = addr_ptr_q;
                  mem_wdata_d = byte_in;
                  if (AUTO_INC) addr_ptr_d = addr_ptr_q + ADDRWIDTH'(1);
                  state_d     = ST_WR_ACK;
                end
              endcase
            end
          end
        end

        // First fall after the byte drives ACK; the fall after the ACK clock releases it
        ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              if (state_q != ST_DEV_ACK) state_d = ST_WR_DATA;
              else if (rw_q)             rd_issue = 1'b1;
              else                       state_d = ST_REG_ADDR;
            end
          end
        end

        // Data is fetched inside the SCL low period, so the MSB goes out without waiting for a fall
        ST_RD_LOAD: begin
          if (rd_cnt_q == 4'(READ_LAT)) begin
            tx_d      = mem_rdata;
            sda_oe_d  = ~mem_rdata[7];
            bit_cnt_d = '0;
            state_d   = ST_RD_DATA;
          end else begin
            rd_cnt_d = rd_cnt_q + 4'd1;
          end
        end

        ST_RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              phase_d   = 1'b0;
              state_d   = ST_RD_ACK;
            end else begin
              tx_d     = {tx_q[6:0], 1'b0};
              sda_oe_d = ~tx_q[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (!phase_q) begin
            if (scl_rise) begin
              if (sda_s) state_d = ST_WAIT_STOP;
              else       phase_d = 1'b1;
            end
          end else if (scl_fall) begin
            phase_d  = 1'b0;
            rd_issue = 1'b1;
          end
        end

        default: ;
      endcase
    end

    if (rd_issue) begin
      state_d     = ST_RD_LOAD;
      mem_rd_en_d = 1'b1;
      mem_addr_d  = addr_ptr_q;
      rd_cnt_d    = '0;
      if (AUTO_INC) addr_ptr_d = addr_ptr_q + ADDRWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      addr_ptr_q  <= '0;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      rd_cnt_q    <= '0;
      busy_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_ptr_q  <= addr_ptr_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      rd_cnt_q    <= rd_cnt_d;
      busy_q      <= busy_d;
      sda_oe_q    <= sda_oe_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
